// File: rtl/operand_mem_responder_if.sv
// Bus bundle between the approximate-multiplier controller/host and the
// operand memory responder.
//   slave  modport : responder side (receives strobes/data, drives responses)
//   master modport : controller/host side
// Signals:
//   fill_en/fill_data     host operand fill
//   loadMem               start of run
//   readMem/rd_data/rd_valid
//                         operand read strobe and registered response
//   storeMem/wr_data      result write strobe and data
//   opDone                all results written (usable in the strobe cycle)
//   save                  start result dump
//   dump_valid/dump_idx/dump_data
//                         result dump stream
//   busy                  responder not idle
//   err                   sticky protocol error
interface operand_mem_responder_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned NUM_OPS = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_OPS);

  logic              fill_en;
  logic [DATA_W-1:0] fill_data;
  logic              loadMem;
  logic              readMem;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              storeMem;
  logic [RES_W-1:0]  wr_data;
  logic              opDone;
  logic              save;
  logic              dump_valid;
  logic [IDX_W-1:0]  dump_idx;
  logic [RES_W-1:0]  dump_data;
  logic              busy;
  logic              err;

  modport slave (
    input  fill_en, fill_data, loadMem, readMem, storeMem, wr_data, save,
    output rd_data, rd_valid, opDone, dump_valid, dump_idx, dump_data, busy, err
  );

  modport master (
    output fill_en, fill_data, loadMem, readMem, storeMem, wr_data, save,
    input  rd_data, rd_valid, opDone, dump_valid, dump_idx, dump_data, busy, err
  );
endinterface

// File: rtl/operand_mem_responder.sv
// Memory-side responder for the approximate-multiplier controller.
// Owns the operand RAM (2*NUM_OPS words, order A0,B0,A1,B1,...) and the
// result RAM (NUM_OPS words) plus all address pointers, so the controller
// only issues strobes.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : operand_mem_responder_if.slave (fill, read, write, dump, status)
// Flow: IDLE -(loadMem)-> SERVE -(save)-> DUMP -(last index)-> IDLE.
// save in IDLE re-dumps the last results; loadMem in DUMP is ignored.
// Optional build macro OPMEM_PROTO_CHECK_EN: drives a sticky err flag on
// protocol violations; without it err is tied low.
// NUM_OPS must be at least 2.
module operand_mem_responder #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned NUM_OPS = 8
) (
  input  logic clk,
  input  logic rst,
  operand_mem_responder_if.slave bus
);

  localparam int unsigned OP_DEPTH = 2 * NUM_OPS;
  localparam int unsigned PTR_W    = $clog2(OP_DEPTH);
  localparam int unsigned WR_W     = $clog2(NUM_OPS + 1);
  localparam int unsigned IDX_W    = $clog2(NUM_OPS);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OP_DEPTH - 1);
  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(NUM_OPS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DUMP  = 2'd2
  } state_t;

  state_t state, nextState;

  logic [DATA_W-1:0] opRam  [OP_DEPTH];
  logic [RES_W-1:0]  resRam [NUM_OPS];

  logic [PTR_W-1:0]  fillPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [WR_W-1:0]   wrPtr;
  logic [IDX_W-1:0]  dumpIdx;
  logic              opDoneReg;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;

  logic loadAccept;
  logic fillFire;
  logic rdFire;
  logic wrFire;
  logic lastWrite;
  logic opDoneNow;

  // loadMem restarts a run from IDLE or SERVE; strobes arriving in the same
  // cycle as a restart are dropped so the pointers start cleanly at 0.
  always_comb begin
    loadAccept = bus.loadMem && (state != DUMP);
    fillFire   = bus.fill_en && (state == IDLE);
    rdFire     = bus.readMem && (state == SERVE) && !loadAccept;
    wrFire     = bus.storeMem && (state == SERVE) && !loadAccept && !opDoneReg;
    lastWrite  = wrFire && (wrPtr == WR_LAST);
    // The controller samples opDone in the cycle of the final store, so the
    // flag is bypassed combinationally from that store.
    opDoneNow  = opDoneReg || lastWrite;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (bus.loadMem) begin
          nextState = SERVE;
        end else if (bus.save) begin
          nextState = DUMP;
        end
      end
      SERVE: begin
        if (bus.save && !bus.loadMem) begin
          nextState = DUMP;
        end
      end
      DUMP: begin
        if (dumpIdx == IDX_LAST) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // RAM arrays carry no reset; only the pointers do.
  always_ff @(posedge clk) begin
    if (fillFire) begin
      opRam[fillPtr] <= bus.fill_data;
    end
    if (wrFire) begin
      resRam[wrPtr[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fillPtr <= '0;
    end else if (fillFire) begin
      fillPtr <= (fillPtr == PTR_LAST) ? '0 : fillPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || loadAccept) begin
      rdPtr <= '0;
    end else if (rdFire) begin
      rdPtr <= (rdPtr == PTR_LAST) ? '0 : rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= rdFire;
      if (rdFire) begin
        rdData <= opRam[rdPtr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || loadAccept) begin
      wrPtr     <= '0;
      opDoneReg <= 1'b0;
    end else if (wrFire) begin
      wrPtr <= wrPtr + 1'b1;
      if (lastWrite) begin
        opDoneReg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != DUMP) begin
      dumpIdx <= '0;
    end else begin
      dumpIdx <= (dumpIdx == IDX_LAST) ? '0 : dumpIdx + 1'b1;
    end
  end

  assign bus.rd_data    = rdData;
  assign bus.rd_valid   = rdValid;
  assign bus.opDone     = opDoneNow;
  assign bus.busy       = (state != IDLE);
  assign bus.dump_valid = (state == DUMP);
  assign bus.dump_idx   = (state == DUMP) ? dumpIdx : '0;
  assign bus.dump_data  = (state == DUMP) ? resRam[dumpIdx] : '0;

`ifdef OPMEM_PROTO_CHECK_EN
  logic errReg;
  logic violation;

  always_comb begin
    violation = ((bus.readMem || bus.storeMem) && (state != SERVE))
             || (bus.storeMem && (state == SERVE) && opDoneReg)
             || (bus.fill_en && (state != IDLE))
             || (rdFire && (rdPtr == PTR_LAST) && !opDoneNow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errReg <= 1'b0;
    end else if (violation) begin
      errReg <= 1'b1;
    end
  end

  assign bus.err = errReg;
`else
  assign bus.err = 1'b0;
`endif

endmodule
